// File: rtl/gpio_cmd_master.sv
// gpio_cmd_master: host-side initiator for the UART GPIO command protocol.
// Serialises one request as a 4-byte frame (op, bank, pin, data), checks the
// echo of every byte and returns one response with a status code.
// Optional feature macro: GPIO_CMD_ERRCNT_EN adds a saturating error counter
// output (err_count) that counts responses with a non-zero code.
module gpio_cmd_master #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_bank,
  input  logic [7:0] req_pin,
  input  logic [7:0] req_data,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rsp_valid,
  output logic [1:0] rsp_code,
  output logic [7:0] rsp_echo
`ifdef GPIO_CMD_ERRCNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam logic [23:0] TIMEOUT_CNT = 24'(TIMEOUT);

  localparam logic [1:0] CODE_OK       = 2'd0;
  localparam logic [1:0] CODE_MISMATCH = 2'd1;
  localparam logic [1:0] CODE_TIMEOUT  = 2'd2;
  localparam logic [1:0] CODE_BAD_OP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ECHO,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  bank_q, bank_d;
  logic [7:0]  pin_q, pin_d;
  logic [7:0]  data_q, data_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] cnt_q, cnt_d;
  logic [7:0]  echo_q, echo_d;
  logic        req_ready_q, req_ready_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_code_q, rsp_code_d;
  logic [7:0]  rsp_echo_q, rsp_echo_d;
  logic [7:0]  expected_echo;

  // Frame byte at a given position of the request.
  function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [1:0] op,
                                            input logic [7:0] bank, input logic [7:0] pin,
                                            input logic [7:0] data);
    logic [7:0] b;
    case (idx)
      2'd0:    b = {6'b0, op};
      2'd1:    b = bank;
      2'd2:    b = pin;
      default: b = data;
    endcase
    return b;
  endfunction

  // Echo the responder must return for the byte currently in flight; the
  // data byte of a config frame is acknowledged with a fixed 8'h35.
  always_comb begin
    expected_echo = frame_byte(idx_q, op_q, bank_q, pin_q, data_q);
    if (idx_q == 2'd3 && op_q == 2'd2) begin
      expected_echo = 8'h35;
    end
  end

  // Next-state logic; a byte is launched in the same cycle the FSM decides to
  // send whenever the transmitter is free, so SEND is only used under backpressure.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    bank_d      = bank_q;
    pin_d       = pin_q;
    data_d      = data_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    echo_d      = echo_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    rsp_valid_d = 1'b0;
    rsp_code_d  = rsp_code_q;
    rsp_echo_d  = rsp_echo_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          op_d   = req_op;
          bank_d = req_bank;
          pin_d  = req_pin;
          data_d = req_data;
          idx_d  = 2'd0;
          echo_d = 8'h00;
          if (req_op == 2'd3) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_code_d  = CODE_BAD_OP;
            rsp_echo_d  = 8'h00;
          end else if (!tx_busy) begin
            tx_start_d = 1'b1;
            tx_data_d  = {6'b0, req_op};
            cnt_d      = 24'd0;
            state_d    = WAIT_ECHO;
          end else begin
            state_d = SEND;
          end
        end
      end

      SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = frame_byte(idx_q, op_q, bank_q, pin_q, data_q);
          cnt_d      = 24'd0;
          state_d    = WAIT_ECHO;
        end
      end

      WAIT_ECHO: begin
        cnt_d = cnt_q + 24'd1;
        if (rx_valid) begin
          echo_d = rx_data;
          if (rx_data != expected_echo) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_code_d  = CODE_MISMATCH;
            rsp_echo_d  = rx_data;
          end else if (idx_q == 2'd3) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_code_d  = CODE_OK;
            rsp_echo_d  = rx_data;
          end else begin
            idx_d = idx_q + 2'd1;
            if (!tx_busy) begin
              tx_start_d = 1'b1;
              tx_data_d  = frame_byte(idx_q + 2'd1, op_q, bank_q, pin_q, data_q);
              cnt_d      = 24'd0;
            end else begin
              state_d = SEND;
            end
          end
        end else if (cnt_q == TIMEOUT_CNT) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_code_d  = CODE_TIMEOUT;
          rsp_echo_d  = echo_q;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
  end

  // State and registered outputs; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= 2'd0;
      bank_q      <= 8'h00;
      pin_q       <= 8'h00;
      data_q      <= 8'h00;
      idx_q       <= 2'd0;
      cnt_q       <= 24'd0;
      echo_q      <= 8'h00;
      req_ready_q <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_code_q  <= 2'd0;
      rsp_echo_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      bank_q      <= bank_d;
      pin_q       <= pin_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      echo_q      <= echo_d;
      req_ready_q <= req_ready_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_code_q  <= rsp_code_d;
      rsp_echo_q  <= rsp_echo_d;
    end
  end

  assign req_ready = req_ready_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_code  = rsp_code_q;
  assign rsp_echo  = rsp_echo_q;

`ifdef GPIO_CMD_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating count of failed responses, launched together with rsp_valid.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (rsp_valid_d && rsp_code_d != CODE_OK && err_cnt_q != 16'hFFFF) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Error counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 16'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_gpio_cmd_master.sv
// Testbench for gpio_cmd_master: directed and randomized requests against a
// frame-level reference model. Define GPIO_CMD_ERRCNT_EN to also exercise err_count.
module tb_gpio_cmd_master;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'd0;
  logic [7:0] req_bank = 8'h00;
  logic [7:0] req_pin = 8'h00;
  logic [7:0] req_data = 8'h00;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rsp_valid;
  logic [1:0] rsp_code;
  logic [7:0] rsp_echo;
`ifdef GPIO_CMD_ERRCNT_EN
  logic [15:0] err_count;
`endif

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  gpio_cmd_master #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_bank  (req_bank),
    .req_pin   (req_pin),
    .req_data  (req_data),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rsp_valid (rsp_valid),
    .rsp_code  (rsp_code),
    .rsp_echo  (rsp_echo)
`ifdef GPIO_CMD_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errs++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset(input int n);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    rx_valid = 1'b0;
    tx_busy = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitReady(input string tag);
    int w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) checkOutput({tag, " ready_wait"}, 32'(req_ready), 32'd1);
  endtask

  // One request: the bench models the frame, the responder's echoes and the
  // expected timing, then drives the DUT cycle by cycle and compares.
  // delay: echo latency after tx_start; busy: tx_busy cycles from acceptance;
  // bad_idx/bad_val: corrupted echo; drop_idx: byte whose echo never arrives.
  task automatic applyStimulus(input string name, input logic [1:0] op, input logic [7:0] bank,
                               input logic [7:0] pin, input logic [7:0] data, input int delay,
                               input int busy, input int bad_idx, input logic [7:0] bad_val,
                               input int drop_idx);
    logic [7:0] frame [4];
    logic [7:0] want [4];
    logic [7:0] exp_sent [$];
    int         exp_times [$];
    logic [1:0] exp_code;
    logic [7:0] exp_echo;
    int         exp_rsp;
    logic [7:0] got_sent [$];
    int         got_times [$];
    logic [1:0] got_code = 2'd0;
    logic [7:0] got_echo = 8'h00;
    int         got_rsp = -1;
    int         s, t0, rel, n_tx, pend_at;
    logic [7:0] pend_val;
    logic       pend;
    logic       ready_at_rsp = 1'b1;

    frame[0] = {6'b0, op};
    frame[1] = bank;
    frame[2] = pin;
    frame[3] = data;
    for (int i = 0; i < 4; i++) want[i] = frame[i];
    if (op == 2'd2) want[3] = 8'h35;

    exp_code = 2'd0;
    exp_echo = 8'h00;
    exp_rsp  = 1;
    if (op == 2'd3) begin
      exp_code = 2'd3;
      exp_rsp  = 1;
    end else begin
      s = 1 + busy;
      for (int i = 0; i < 4; i++) begin
        logic [7:0] e;
        exp_sent.push_back(frame[i]);
        exp_times.push_back(s);
        if (i == drop_idx) begin
          exp_code = 2'd2;
          exp_rsp  = s + TMO + 1;
          break;
        end
        e = (i == bad_idx) ? bad_val : want[i];
        exp_echo = e;
        if (e != want[i]) begin
          exp_code = 2'd1;
          exp_rsp  = s + delay + 1;
          break;
        end
        if (i == 3) begin
          exp_code = 2'd0;
          exp_rsp  = s + delay + 1;
          break;
        end
        s = s + delay + 1;
      end
    end

    waitReady(name);
    req_valid = 1'b1;
    req_op    = op;
    req_bank  = bank;
    req_pin   = pin;
    req_data  = data;
    tx_busy   = (busy > 0);
    t0   = cyc;
    n_tx = 0;
    pend = 1'b0;
    pend_at = 0;
    pend_val = 8'h00;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      rel = cyc - t0;
      req_valid = 1'b0;
      rx_valid  = 1'b0;
      tx_busy   = (rel < busy);
      if (tx_start) begin
        got_sent.push_back(tx_data);
        got_times.push_back(rel);
        if (n_tx != drop_idx && n_tx < 4) begin
          pend     = 1'b1;
          pend_at  = rel + delay;
          pend_val = (n_tx == bad_idx) ? bad_val : want[n_tx];
        end
        n_tx++;
      end
      if (rsp_valid) begin
        got_code = rsp_code;
        got_echo = rsp_echo;
        got_rsp  = rel;
        ready_at_rsp = req_ready;
        break;
      end
      if (pend && rel == pend_at) begin
        rx_valid = 1'b1;
        rx_data  = pend_val;
        pend     = 1'b0;
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
    tx_busy  = 1'b0;

    checkOutput({name, " n_tx"}, 32'(got_sent.size()), 32'(exp_sent.size()));
    for (int i = 0; i < exp_sent.size() && i < got_sent.size(); i++) begin
      checkOutput($sformatf("%s tx_data%0d", name, i), 32'(got_sent[i]), 32'(exp_sent[i]));
      checkOutput($sformatf("%s tx_time%0d", name, i), 32'(got_times[i]), 32'(exp_times[i]));
    end
    checkOutput({name, " rsp_cycle"}, 32'(got_rsp), 32'(exp_rsp));
    checkOutput({name, " rsp_code"}, 32'(got_code), 32'(exp_code));
    checkOutput({name, " rsp_echo"}, 32'(got_echo), 32'(exp_echo));
    checkOutput({name, " ready_during_rsp"}, 32'(ready_at_rsp), 32'd0);
    checkOutput({name, " rsp_one_cycle"}, 32'(rsp_valid), 32'd0);
    checkOutput({name, " ready_after_rsp"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int n_tx, n_rsp, w;

    $display("[TB] starting gpio_cmd_master bench");

    // Reset values while rst is held and the first cycle after release.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset tx_start", 32'(tx_start), 32'd0);
    checkOutput("reset tx_data", 32'(tx_data), 32'd0);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset rsp_code", 32'(rsp_code), 32'd0);
    checkOutput("reset rsp_echo", 32'(rsp_echo), 32'd0);
`ifdef GPIO_CMD_ERRCNT_EN
    checkOutput("reset err_count", 32'(err_count), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready after reset", 32'(req_ready), 32'd1);

    // Directed requests.
    applyStimulus("write",      2'd1, 8'h00, 8'h05, 8'h01, 4,   0, -1, 8'h00, -1);
    applyStimulus("config_ok",  2'd2, 8'h03, 8'h07, 8'h09, 4,   0, -1, 8'h00, -1);
    applyStimulus("config_bad", 2'd2, 8'h03, 8'h07, 8'h09, 4,   0,  3, 8'h09, -1);
    applyStimulus("mismatch",   2'd0, 8'h00, 8'h02, 8'h00, 3,   0,  1, 8'h04, -1);
    applyStimulus("timeout",    2'd1, 8'h01, 8'h02, 8'h01, 4,   0, -1, 8'h00,  0);
    applyStimulus("timeout_b2", 2'd0, 8'h11, 8'h22, 8'h00, 2,   0, -1, 8'h00,  2);
    applyStimulus("echo_at_tmo",2'd1, 8'h0A, 8'h0B, 8'h00, TMO, 0, -1, 8'h00, -1);
    applyStimulus("bad_op",     2'd3, 8'h12, 8'h34, 8'h56, 4,   0, -1, 8'h00, -1);
    applyStimulus("busy10",     2'd1, 8'h02, 8'h03, 8'h01, 2,  10, -1, 8'h00, -1);

    // Stray byte while idle must be discarded silently.
    waitReady("stray");
    rx_valid = 1'b1;
    rx_data  = 8'h01;
    @(negedge clk);
    rx_valid = 1'b0;
    n_tx = 0;
    n_rsp = 0;
    for (int k = 0; k < 8; k++) begin
      if (tx_start) n_tx++;
      if (rsp_valid) n_rsp++;
      @(negedge clk);
    end
    checkOutput("stray n_rsp", 32'(n_rsp), 32'd0);
    checkOutput("stray n_tx", 32'(n_tx), 32'd0);
    checkOutput("stray ready", 32'(req_ready), 32'd1);

    // Randomized requests.
    for (int r = 0; r < 24; r++) begin
      logic [1:0] op;
      int bad_idx, drop_idx;
      op = 2'($urandom_range(0, 3));
      bad_idx  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      drop_idx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
      applyStimulus($sformatf("rand%0d", r), op, 8'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, TMO)), int'($urandom_range(0, 3)),
                    bad_idx, 8'($urandom), drop_idx);
    end

    // Reset while waiting for an echo aborts the frame.
    waitReady("rst_wait");
    req_valid = 1'b1;
    req_op    = 2'd1;
    req_bank  = 8'h01;
    req_pin   = 8'h02;
    req_data  = 8'h00;
    @(negedge clk);
    req_valid = 1'b0;
    w = 0;
    while (!tx_start && w < 20) begin
      @(negedge clk);
      w++;
    end
    checkOutput("rst_wait tx_seen", 32'(tx_start), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_tx = 0;
    n_rsp = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (tx_start) n_tx++;
      if (rsp_valid) n_rsp++;
    end
    checkOutput("rst_wait n_tx", 32'(n_tx), 32'd0);
    checkOutput("rst_wait n_rsp", 32'(n_rsp), 32'd0);
    checkOutput("rst_wait ready", 32'(req_ready), 32'd1);

`ifdef GPIO_CMD_ERRCNT_EN
    // Three failing requests, then reset clears the counter.
    doReset(2);
    checkOutput("errcnt start", 32'(err_count), 32'd0);
    applyStimulus("err_badop", 2'd3, 8'h00, 8'h00, 8'h00, 2, 0, -1, 8'h00, -1);
    applyStimulus("err_mism",  2'd1, 8'h05, 8'h06, 8'h01, 2, 0,  0, 8'hEE, -1);
    applyStimulus("err_ok",    2'd0, 8'h05, 8'h06, 8'h00, 2, 0, -1, 8'h00, -1);
    applyStimulus("err_tmo",   2'd0, 8'h07, 8'h08, 8'h00, 2, 0, -1, 8'h00,  1);
    checkOutput("errcnt three", 32'(err_count), 32'd3);
    doReset(2);
    checkOutput("errcnt cleared", 32'(err_count), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
